// File: rtl/dds_pkg.sv
// Shared types for the DDS audio path: envelope state encoding and the
// default sample/envelope widths used by the envelope VCA.
package dds_pkg;

  // 3-bit ADSR state encoding, visible on the env_state output.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam int OW_DEFAULT = 24;
  localparam int EW_DEFAULT = 16;

endpackage

// File: rtl/envelope_gen.sv
// ADSR envelope generator: state machine plus saturating/clamping level
// register. Everything advances only on accepted samples (i_valid=1); gate
// changes take priority over the rate arithmetic of the current state.
module envelope_gen
  import dds_pkg::*;
#(
  parameter int EW = EW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic          i_gate,
  input  logic [EW-1:0] i_attack_rate,
  input  logic [EW-1:0] i_decay_rate,
  input  logic [EW-1:0] i_sustain_level,
  input  logic [EW-1:0] i_release_rate,
  output logic [EW-1:0] o_level,
  output env_state_t    o_state
);

  localparam logic [EW-1:0] FULL = '1;

  env_state_t    r_state, w_next_state;
  logic [EW-1:0] r_level, w_next_level;

  // One extra bit: carry for the attack sum, borrow for the decrements.
  logic [EW:0] w_sum, w_dec, w_rel;

  assign w_sum = {1'b0, r_level} + {1'b0, i_attack_rate};
  assign w_dec = {1'b0, r_level} - {1'b0, i_decay_rate};
  assign w_rel = {1'b0, r_level} - {1'b0, i_release_rate};

  // Next state and next level for the current sample.
  always_comb begin
    // NOTE: hold-current defaults first, so no path through the case leaves
    // a variable unassigned and no latch is inferred.
    w_next_state = r_state;
    w_next_level = r_level;
    case (r_state)
      ST_IDLE: begin
        w_next_level = '0;
        if (i_gate) begin
          w_next_state = ST_ATTACK;
          w_next_level = w_sum[EW] ? FULL : w_sum[EW-1:0];
        end
      end
      ST_ATTACK: begin
        if (!i_gate) begin
          w_next_state = ST_RELEASE;
        end else if (w_sum[EW] || (w_sum[EW-1:0] == FULL)) begin
          w_next_level = FULL;
          w_next_state = ST_DECAY;
        end else begin
          w_next_level = w_sum[EW-1:0];
        end
      end
      ST_DECAY: begin
        // A borrow or a landing at/below sustain both clamp to sustain; this
        // also covers entering DECAY already below the sustain level.
        if (!i_gate) begin
          w_next_state = ST_RELEASE;
        end else if (w_dec[EW] || (w_dec[EW-1:0] <= i_sustain_level)) begin
          w_next_level = i_sustain_level;
          w_next_state = ST_SUSTAIN;
        end else begin
          w_next_level = w_dec[EW-1:0];
        end
      end
      ST_SUSTAIN: begin
        if (!i_gate) begin
          w_next_state = ST_RELEASE;
        end else begin
          w_next_level = i_sustain_level;
        end
      end
      ST_RELEASE: begin
        // Retrigger resumes attack from wherever the level currently is.
        if (i_gate) begin
          w_next_state = ST_ATTACK;
        end else if (w_rel[EW] || (w_rel[EW-1:0] == '0)) begin
          w_next_level = '0;
          w_next_state = ST_IDLE;
        end else begin
          w_next_level = w_rel[EW-1:0];
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_level = '0;
      end
    endcase
  end

  // State and level registers, updated only on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_level <= '0;
    end else if (i_valid) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_next_state;
      r_level <= w_next_level;
    end
  end

  assign o_level = r_level;
  assign o_state = r_state;

endmodule

// File: rtl/envelope_vca.sv
// Envelope VCA: scales the signed DDS sample stream by an ADSR envelope.
// Two-stage pipeline (product, then shift), out_valid = in_valid + 2 cycles.
// Each sample is scaled by the envelope level from before its own update.
// Optional macro ENVELOPE_VCA_ROUND_EN: round half up instead of truncating.
module envelope_vca
  import dds_pkg::*;
#(
  parameter int OW = OW_DEFAULT,
  parameter int EW = EW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gate,
  input  logic [EW-1:0] attack_rate,
  input  logic [EW-1:0] decay_rate,
  input  logic [EW-1:0] sustain_level,
  input  logic [EW-1:0] release_rate,
  input  logic          in_valid,
  input  logic [OW-1:0] in_ampl,
  output logic          out_valid,
  output logic [OW-1:0] out_ampl,
  output logic [EW-1:0] env_level,
  output logic [2:0]    env_state,
  output logic          busy
);

  localparam int PW = OW + EW + 1;

  env_state_t    w_state;
  logic [EW-1:0] w_level;

  envelope_gen #(.EW(EW)) u_env (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_valid         (in_valid),
    .i_gate          (gate),
    .i_attack_rate   (attack_rate),
    .i_decay_rate    (decay_rate),
    .i_sustain_level (sustain_level),
    .i_release_rate  (release_rate),
    .o_level         (w_level),
    .o_state         (w_state)
  );

  // Both operands widened to the full product width; the level is
  // zero-extended so it is treated as a non-negative gain.
  logic signed [PW-1:0] w_a, w_b, w_prod, w_biased, w_shift;
  logic signed [PW-1:0] r_prod;
  logic                 r_v1;
  logic                 r_out_valid;
  logic [OW-1:0]        r_out_ampl;

  assign w_a    = PW'($signed(in_ampl));
  assign w_b    = PW'($signed({1'b0, w_level}));
  assign w_prod = w_a * w_b;

`ifdef ENVELOPE_VCA_ROUND_EN
  localparam logic signed [PW-1:0] ROUND_K = PW'(1) << (EW - 1);
  assign w_biased = r_prod + ROUND_K;
`else
  assign w_biased = r_prod;
`endif

  assign w_shift = w_biased >>> EW;

  // The gain never exceeds unity, so the bits above OW are pure sign copies.
  logic w_unused_hi;
  assign w_unused_hi = ^w_shift[PW-1:OW];

  // Stage 1: register the full-precision product of each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) r_prod <= w_prod;
    end
  end

  // Stage 2: register the shifted result; holds between valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_ampl  <= '0;
    end else begin
      r_out_valid <= r_v1;
      if (r_v1) r_out_ampl <= w_shift[OW-1:0];
    end
  end

  assign out_valid = r_out_valid;
  assign out_ampl  = r_out_ampl;
  assign env_level = w_level;
  assign env_state = w_state;
  assign busy      = (w_state != ST_IDLE);

endmodule

// File: tb/tb_envelope_vca.sv
// Directed self-checking bench for envelope_vca (OW=24, EW=16).
module tb_envelope_vca;
  import dds_pkg::*;

  localparam int OW = 24;
  localparam int EW = 16;

  logic          clk;
  logic          rst_n;
  logic          gate;
  logic [EW-1:0] attack_rate, decay_rate, sustain_level, release_rate;
  logic          in_valid;
  logic [OW-1:0] in_ampl;
  logic          out_valid;
  logic [OW-1:0] out_ampl;
  logic [EW-1:0] env_level;
  logic [2:0]    env_state;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ENVELOPE_VCA_ROUND_EN
  localparam logic [OW-1:0] EXP_POS1 = 24'h000001;
  localparam logic [OW-1:0] EXP_NEG1 = 24'h000000;
`else
  localparam logic [OW-1:0] EXP_POS1 = 24'h000000;
  localparam logic [OW-1:0] EXP_NEG1 = 24'hFFFFFF;
`endif

  envelope_vca #(.OW(OW), .EW(EW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .in_valid      (in_valid),
    .in_ampl       (in_ampl),
    .out_valid     (out_valid),
    .out_ampl      (out_ampl),
    .env_level     (env_level),
    .env_state     (env_state),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; gate = 1'b0; in_valid = 1'b0; in_ampl = '0;
    attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_ampl",  32'(out_ampl),  32'h0);
    check("rst_env_level", 32'(env_level), 32'h0);
    check("rst_env_state", 32'(env_state), 32'(ST_IDLE));
    check("rst_busy",      32'(busy),      32'h0);
    rst_n = 1'b1;

    // Attack: 0x1000 per sample, saturating on sample 16.
    gate = 1'b1; attack_rate = 16'h1000; decay_rate = 16'h2000;
    sustain_level = 16'h8000; release_rate = 16'h3000;
    in_valid = 1'b1; in_ampl = '0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("attack_level", 32'(env_level), 32'(k) * 32'h1000);
    end
    check("attack_state", 32'(env_state), 32'(ST_ATTACK));
    check("attack_busy",  32'(busy),      32'h1);
    tick();
    check("attack_sat",       32'(env_level), 32'hFFFF);
    check("attack_to_decay",  32'(env_state), 32'(ST_DECAY));

    // Decay to sustain 0x8000.
    tick(); check("decay_1", 32'(env_level), 32'hDFFF);
    tick(); check("decay_2", 32'(env_level), 32'hBFFF);
    tick(); check("decay_3", 32'(env_level), 32'h9FFF);
    check("decay_state", 32'(env_state), 32'(ST_DECAY));
    tick(); check("decay_clamp", 32'(env_level), 32'h8000);
    check("sustain_state", 32'(env_state), 32'(ST_SUSTAIN));

    // Scaling at half gain, two-cycle latency.
    in_ampl = 24'h400000; tick();
    in_ampl = 24'h000000; tick();
    check("scale_half_valid", 32'(out_valid), 32'h1);
    check("scale_half",       32'(out_ampl),  32'h200000);

    // Sustain follows live changes.
    sustain_level = 16'h4000; tick();
    check("sustain_track_lo", 32'(env_level), 32'h4000);
    sustain_level = 16'h8000; tick();
    check("sustain_track_hi", 32'(env_level), 32'h8000);

    // Release to idle.
    gate = 1'b0; tick();
    check("release_enter_state", 32'(env_state), 32'(ST_RELEASE));
    check("release_enter_level", 32'(env_level), 32'h8000);
    tick(); check("release_1", 32'(env_level), 32'h5000);
    tick(); check("release_2", 32'(env_level), 32'h2000);
    tick(); check("release_clamp", 32'(env_level), 32'h0000);
    check("release_idle", 32'(env_state), 32'(ST_IDLE));
    check("release_busy", 32'(busy),      32'h0);
    tick(); check("idle_hold", 32'(env_level), 32'h0000);

    // Full-scale gain with a negative sample.
    attack_rate = 16'hFFFF; gate = 1'b1; tick();
    check("fs_attack_level", 32'(env_level), 32'hFFFF);
    check("fs_attack_state", 32'(env_state), 32'(ST_ATTACK));
    in_ampl = 24'hC00000; tick();
    check("fs_to_decay", 32'(env_state), 32'(ST_DECAY));
    in_ampl = 24'h000000; tick();
    check("scale_full", 32'(out_ampl), 32'hC00040);
    attack_rate = 16'h1000;
    tick(); tick(); tick();
    check("redecay_sustain", 32'(env_level), 32'h8000);

    // Release then retrigger at 0x2000.
    gate = 1'b0; tick(); tick(); tick();
    check("retrig_pre_level", 32'(env_level), 32'h2000);
    gate = 1'b1; tick();
    check("retrig_state", 32'(env_state), 32'(ST_ATTACK));
    check("retrig_level", 32'(env_level), 32'h2000);
    tick();
    check("retrig_continue", 32'(env_level), 32'h3000);

    // Sparse strobes: one valid every third cycle.
    in_valid = 1'b0; tick(); tick(); tick();
    check("gap_hold_level", 32'(env_level), 32'h3000);
    check("gap_flush_valid", 32'(out_valid), 32'h0);
    for (int p = 0; p < 3; p++) begin
      in_valid = 1'b1; in_ampl = 24'h400000; tick();
      check("gap_strobe_level", 32'(env_level), 32'h4000 + 32'(p) * 32'h1000);
      check("gap_strobe_noval", 32'(out_valid), 32'h0);
      in_valid = 1'b0; in_ampl = '0; tick();
      check("gap_out_valid", 32'(out_valid), 32'h1);
      check("gap_out_ampl",  32'(out_ampl), (32'h3000 + 32'(p) * 32'h1000) * 32'd64);
      tick();
      check("gap_out_idle",  32'(out_valid), 32'h0);
      check("gap_out_hold",  32'(out_ampl), (32'h3000 + 32'(p) * 32'h1000) * 32'd64);
      check("gap_level_hold", 32'(env_level), 32'h4000 + 32'(p) * 32'h1000);
    end

    // Async reset between edges while attacking.
    in_valid = 1'b1; in_ampl = 24'h400000; tick(); tick();
    check("pre_reset_valid", 32'(out_valid), 32'h1);
    check("pre_reset_ampl",  32'(out_ampl),  32'h180000);
    #3 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'h0);
    check("async_out_ampl",  32'(out_ampl),  32'h0);
    check("async_env_level", 32'(env_level), 32'h0);
    check("async_busy",      32'(busy),      32'h0);
    check("async_state",     32'(env_state), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1; gate = 1'b1; attack_rate = 16'h1000; in_ampl = '0;
    tick();
    check("restart_level", 32'(env_level), 32'h1000);
    check("restart_state", 32'(env_state), 32'(ST_ATTACK));

    // Rounding boundary at half gain, zero attack rate holds the level.
    attack_rate = 16'h7000; tick();
    check("round_setup_level", 32'(env_level), 32'h8000);
    attack_rate = 16'h0000; in_ampl = 24'h000001; tick();
    check("rate0_hold", 32'(env_level), 32'h8000);
    in_ampl = 24'hFFFFFF; tick();
    check("round_pos1", 32'(out_ampl), 32'(EXP_POS1));
    in_ampl = 24'h000000; tick();
    check("round_neg1", 32'(out_ampl), 32'(EXP_NEG1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
